// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into R/I/S/B/J words and writes them to
// consecutive instruction-memory addresses. Define ENCODER_RANGE_CHECK_EN to reject out-of-range immediates.
module inst_encoder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  fld_valid,
  output logic                  fld_ready,
  input  logic [6:0]            fld_opcode,
  input  logic [2:0]            fld_func3,
  input  logic [6:0]            fld_func7,
  input  logic [4:0]            fld_rd,
  input  logic [4:0]            fld_rs1,
  input  logic [4:0]            fld_rs2,
  input  logic [31:0]           fld_imm,
  input  logic                  fld_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  input  logic                  imem_ack,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] BASE     = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [31:0]           NOP      = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  err_q;
  logic                  last_q;

  logic [31:0] enc_word;
  logic        enc_bad;
  logic        imm_ok;
  logic        fits_12, fits_13, fits_21;

`ifdef ENCODER_RANGE_CHECK_EN
  // Signed-range tests: every bit above the sign bit must replicate it.
  assign fits_12 = (fld_imm[31:11] == {21{fld_imm[11]}});
  assign fits_13 = (fld_imm[31:12] == {20{fld_imm[12]}}) && !fld_imm[0];
  assign fits_21 = (fld_imm[31:20] == {12{fld_imm[20]}}) && !fld_imm[0];
`else
  logic unused_imm;
  assign unused_imm = ^{fld_imm[31:21], fld_imm[0]};
  assign fits_12    = 1'b1;
  assign fits_13    = 1'b1;
  assign fits_21    = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    enc_word = NOP;
    enc_bad  = 1'b0;
    imm_ok   = 1'b1;
    case (fld_opcode)
      OP_R:
        enc_word = {fld_func7, fld_rs2, fld_rs1, fld_func3, fld_rd, fld_opcode};
      OP_IMM, OP_LOAD, OP_JALR: begin
        enc_word = {fld_imm[11:0], fld_rs1, fld_func3, fld_rd, fld_opcode};
        imm_ok   = fits_12;
      end
      OP_STORE: begin
        enc_word = {fld_imm[11:5], fld_rs2, fld_rs1, fld_func3, fld_imm[4:0], fld_opcode};
        imm_ok   = fits_12;
      end
      OP_BRANCH: begin
        enc_word = {fld_imm[12], fld_imm[10:5], fld_rs2, fld_rs1, fld_func3,
                    fld_imm[4:1], fld_imm[11], fld_opcode};
        imm_ok   = fits_13;
      end
      OP_JAL: begin
        enc_word = {fld_imm[20], fld_imm[10:1], fld_imm[11], fld_imm[19:12], fld_rd, fld_opcode};
        imm_ok   = fits_21;
      end
      default: begin
        enc_word = NOP;
        enc_bad  = 1'b1;
      end
    endcase
    if (!imm_ok) begin
      enc_word = NOP;
      enc_bad  = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments; the async reset clears it the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fld_valid) state_d = WRITE;
      WRITE:   if (imem_ack) state_d = (last_q || addr_q == ADDR_MAX) ? DONE : IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Restart wins over everything, including a write still waiting for ack.
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= BASE;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (clear) begin
      addr_q  <= BASE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (fld_valid) begin
          wdata_q <= enc_word;
          last_q  <= fld_last;
          if (enc_bad) err_q <= 1'b1;
        end
        WRITE: if (imem_ack) begin
          count_q <= count_q + 1'b1;
          // The top address ends the program, so the address never wraps.
          if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fld_ready  = (state_q == IDLE);
  assign imem_we    = (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed literal checks plus randomized traffic compared every cycle
// against a transaction-level model built from the RV32I field-packing rules.
module tb_inst_encoder;

  localparam int AW   = 10;
  localparam int BASE = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          fld_valid = 1'b0;
  logic          fld_ready;
  logic [6:0]    fld_opcode = '0;
  logic [2:0]    fld_func3 = '0;
  logic [6:0]    fld_func7 = '0;
  logic [4:0]    fld_rd = '0, fld_rs1 = '0, fld_rs2 = '0;
  logic [31:0]   fld_imm = '0;
  logic          fld_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_ack = 1'b0;
  logic [AW:0]   count;
  logic          done;
  logic          err;

  int n_vec = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  inst_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .fld_valid(fld_valid), .fld_ready(fld_ready),
    .fld_opcode(fld_opcode), .fld_func3(fld_func3), .fld_func7(fld_func7),
    .fld_rd(fld_rd), .fld_rs1(fld_rs1), .fld_rs2(fld_rs2),
    .fld_imm(fld_imm), .fld_last(fld_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
    .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoding: bit fields placed with shifts and masks; range limits as signed integers.
  function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm);
    logic [31:0] w;
    logic        bad;
    logic [31:0] regs;
    int          s;
    s    = $signed(imm);
    bad  = 1'b0;
    w    = 32'h13;
    regs = (32'(rs1) << 15) | (32'(f3) << 12);
    case (op)
      7'h33: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'(op);
      7'h13, 7'h03, 7'h67: begin
        w = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'(op);
`ifdef ENCODER_RANGE_CHECK_EN
        if (s < -2048 || s > 2047) bad = 1'b1;
`endif
      end
      7'h23: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
          | ((imm & 32'h1F) << 7) | 32'(op);
`ifdef ENCODER_RANGE_CHECK_EN
        if (s < -2048 || s > 2047) bad = 1'b1;
`endif
      end
      7'h63: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
          | regs | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
`ifdef ENCODER_RANGE_CHECK_EN
        if (s < -4096 || s > 4095 || (s % 2) != 0) bad = 1'b1;
`endif
      end
      7'h6F: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
          | (32'(rd) << 7) | 32'(op);
`ifdef ENCODER_RANGE_CHECK_EN
        if (s < -1048576 || s > 1048575 || (s % 2) != 0) bad = 1'b1;
`endif
      end
      default: bad = 1'b1;
    endcase
    if (bad) w = 32'h13;
    return {bad, w};
  endfunction

  // Transaction model: one word in flight at most; done once the last or top-address word lands.
  logic [32:0]   m_enc;
  bit            m_busy, m_done, m_err, m_last;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_word;

  always_comb m_enc = model_enc(fld_opcode, fld_func3, fld_func7, fld_rd, fld_rs1, fld_rs2, fld_imm);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_last <= 1'b0;
      m_cnt <= 0; m_addr <= AW'(BASE); m_word <= '0;
    end else if (clear) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_cnt <= 0; m_addr <= AW'(BASE);
    end else if (m_busy) begin
      if (imem_ack) begin
        m_busy <= 1'b0;
        m_cnt  <= m_cnt + 1;
        if (m_last || int'(m_addr) == (1 << AW) - 1) m_done <= 1'b1;
        if (int'(m_addr) != (1 << AW) - 1) m_addr <= m_addr + 1'b1;
      end
    end else if (!m_done && fld_valid) begin
      m_busy <= 1'b1;
      m_word <= m_enc[31:0];
      m_last <= fld_last;
      if (m_enc[32]) m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("ready", 32'(fld_ready), 32'(!m_busy && !m_done));
      check("we",    32'(imem_we),   32'(m_busy));
      check("done",  32'(done),      32'(m_done));
      check("err",   32'(err),       32'(m_err));
      check("count", 32'(count),     32'(m_cnt));
      check("addr",  32'(imem_addr), 32'(m_addr));
      check("wdata", imem_wdata,     m_word);
    end
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input logic last);
    fld_opcode = op; fld_func3 = f3; fld_func7 = f7;
    fld_rd = rd; fld_rs1 = rs1; fld_rs2 = rs2;
    fld_imm = imm; fld_last = last; fld_valid = 1'b1;
  endtask

  task automatic wait_we();
    int k = 0;
    while (!imem_we && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("we_wait", 32'(imem_we), 32'd1);
  endtask

  // Issue one bundle (ack assumed high), check the word on the bus, return after the ack edge.
  task automatic write_one(input string name, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input logic last, input logic [31:0] exp_word);
    @(negedge clk);
    drive(op, f3, f7, rd, rs1, rs2, imm, last);
    @(negedge clk);
    fld_valid = 1'b0;
    wait_we();
    check(name, imem_wdata, exp_word);
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic rand_fields(input bit allow_last);
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 9)
      0: fld_opcode = 7'h33;
      1: fld_opcode = 7'h13;
      2: fld_opcode = 7'h03;
      3: fld_opcode = 7'h67;
      4: fld_opcode = 7'h23;
      5: fld_opcode = 7'h63;
      6: fld_opcode = 7'h6F;
      default: fld_opcode = 7'($urandom);
    endcase
    case ($urandom % 4)
      0: fld_imm = $urandom;
      1: fld_imm = {{20{r[11]}}, r[11:0]};
      2: fld_imm = {{12{r[20]}}, r[20:1], ($urandom % 8 == 0) ? 1'b1 : 1'b0};
      default: fld_imm = {{20{r[12]}}, r[12:1], 1'b0};
    endcase
    fld_func3 = 3'($urandom); fld_func7 = 7'($urandom);
    fld_rd = 5'($urandom); fld_rs1 = 5'($urandom); fld_rs2 = 5'($urandom);
    fld_last  = allow_last && ($urandom % 16 == 0);
    fld_valid = ($urandom % 2 == 0);
    imem_ack  = ($urandom % 4 != 0);
  endtask

  logic [31:0] held_w;
  logic [AW-1:0] held_a;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(fld_ready), 32'd1);
    check("rst_we",    32'(imem_we), 32'd0);
    check("rst_addr",  32'(imem_addr), 32'(BASE));
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    rst = 1'b0;
    imem_ack = 1'b1;
    mon_on = 1'b1;

    write_one("addi", 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093);
    check("addi_count", 32'(count), 32'd1);
    check("addi_err", 32'(err), 32'd0);
    check("model_addi", model_enc(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5)[31:0], 32'h0050_0093);

    // add then sub back to back with ack tied high: second accept two cycles after the first.
    do_clear();
    @(negedge clk);
    drive(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    @(negedge clk);
    check("add_word", imem_wdata, 32'h0020_81B3);
    check("add_addr", 32'(imem_addr), 32'd0);
    drive(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    @(negedge clk);
    check("sub_ready", 32'(fld_ready), 32'd1);
    @(negedge clk);
    fld_valid = 1'b0;
    check("sub_word", imem_wdata, 32'h4020_81B3);
    check("sub_addr", 32'(imem_addr), 32'd1);
    @(negedge clk);

    write_one("sw",  7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020_A423);
    write_one("beq", 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0, 32'hFE20_8CE3);

    do_clear();
`ifdef ENCODER_RANGE_CHECK_EN
    write_one("addi_4096", 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 32'h0000_0013);
    check("addi_4096_err", 32'(err), 32'd1);
`else
    write_one("addi_4096", 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 32'h0000_0093);
    check("addi_4096_err", 32'(err), 32'd0);
`endif
    do_clear();
    write_one("bad_op", 7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0000_0013);
    check("bad_op_err", 32'(err), 32'd1);
    do_clear();
    check("clear_err", 32'(err), 32'd0);

    // Stall with ack low, then reset in the middle of the pending write.
    imem_ack = 1'b0;
    @(negedge clk);
    drive(7'h13, 3'd0, 7'd0, 5'd7, 5'd3, 5'd0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    fld_valid = 1'b0;
    wait_we();
    held_w = imem_wdata;
    held_a = imem_addr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_we", 32'(imem_we), 32'd1);
      check("stall_ready", 32'(fld_ready), 32'd0);
      check("stall_addr", 32'(imem_addr), 32'(held_a));
      check("stall_wdata", imem_wdata, held_w);
    end
    check("stall_word", held_w, 32'hFFF1_8393);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_we", 32'(imem_we), 32'd0);
    check("rst_mid_addr", 32'(imem_addr), 32'(BASE));
    check("rst_mid_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;

    write_one("w1", 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0010_0093);
    write_one("w2", 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 32'h0020_0113);
    write_one("w3", 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1, 32'h0100_00EF);
    check("last_done", 32'(done), 32'd1);
    check("last_ready", 32'(fld_ready), 32'd0);
    check("last_count", 32'(count), 32'd3);
    do_clear();
    check("clr_count", 32'(count), 32'd0);
    check("clr_addr", 32'(imem_addr), 32'(BASE));
    check("clr_ready", 32'(fld_ready), 32'd1);

    // Random traffic with occasional last and occasional restart.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rand_fields(1'b1);
      clear = done ? ($urandom % 4 == 0) : ($urandom % 100 == 0);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // Fill the whole memory without last: the top address must end the program.
    begin
      int k = 0;
      while (!done && k < 12000) begin
        @(negedge clk);
        rand_fields(1'b0);
        k++;
      end
    end
    fld_valid = 1'b0;
    check("full_done", 32'(done), 32'd1);
    check("full_count", 32'(count), 32'(1 << AW));
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d miscompares so far", n_bad);
    $fatal(1, "timeout");
  end

endmodule
